// File: rtl/tj_seq_pkg.sv
// Shared types and constants for the vector sequencer and its record FIFO.
package tj_seq_pkg;

    // Sequencer FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SAMPLE,
        ST_STALL,
        ST_DONE
    } seq_state_e;

    // Default MISR feedback taps (CRC-16-CCITT polynomial).
    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

    // Packed width of one {vec, resp} record.
    function automatic int rec_width(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

endpackage

// File: rtl/tj_vector_sequencer_if.sv
// Stimulus, response, record-stream and status signals of the vector sequencer.
// The master side is the sequencer; the slave side is the DUT and the logger.
interface tj_vector_sequencer_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 1,
    parameter int MISR_W = 16
);
    logic              start;
    logic [IN_W-1:0]   dut_in;
    logic [OUT_W-1:0]  dut_out;
    logic              rec_valid;
    logic              rec_ready;
    logic [IN_W-1:0]   rec_vec;
    logic [OUT_W-1:0]  rec_resp;
    logic [MISR_W-1:0] signature;
    logic              busy;
    logic              done;

    modport master (
        input  start, dut_out, rec_ready,
        output dut_in, rec_valid, rec_vec, rec_resp, signature, busy, done
    );

    modport slave (
        output start, dut_out, rec_ready,
        input  dut_in, rec_valid, rec_vec, rec_resp, signature, busy, done
    );
endinterface

// File: rtl/tj_rec_fifo.sv
// Synchronous first-word-fall-through FIFO for {vector, response} records.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module tj_rec_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_en;
    logic             pop_en;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_en  = pop && !empty;
    assign push_en = push && (!full || pop_en);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge CK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop_en)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_en, pop_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Record storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge CK) begin
        if (push_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/tj_vector_sequencer.sv
// Exhaustive-sweep stimulus generator and response capture for trojan benchmarks.
// Applies every IN_W-bit vector, samples the DUT at the end of each hold window,
// queues {vector, response} records and folds each response into a MISR.
module tj_vector_sequencer
    import tj_seq_pkg::*;
#(
    parameter int              IN_W        = 3,
    parameter int              OUT_W       = 1,
    parameter int              HOLD_CYCLES = 1,
    parameter int              FIFO_DEPTH  = 8,
    parameter int              MISR_W      = 16,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEF_MISR_POLY)
) (
    input logic                   CK,
    input logic                   reset,
    tj_vector_sequencer_if.master bus
);
    localparam int REC_W = rec_width(IN_W, OUT_W);
    localparam int HC_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    typedef struct packed {
        logic [IN_W-1:0]  vec;
        logic [OUT_W-1:0] resp;
    } rec_t;

    seq_state_e        state;
    seq_state_e        state_nxt;
    logic [IN_W-1:0]   vec_q;
    logic [HC_W-1:0]   hold_cnt;
    logic [MISR_W-1:0] sig_q;
    logic [OUT_W-1:0]  resp_hold;
    logic              busy_q;
    logic              done_q;

    logic              start_sweep;
    logic              hold_inc;
    logic              take;
    logic              capture_hold;
    logic              room;
    logic              last_vec;
    logic [OUT_W-1:0]  cur_resp;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    rec_t              fifo_din;
    rec_t              fifo_dout;

    // One MISR step: shift, conditional polynomial feedback, inject response.
    function automatic logic [MISR_W-1:0] misr_next(input logic [MISR_W-1:0] s,
                                                    input logic [OUT_W-1:0]  r);
        logic [MISR_W-1:0] fb;
        fb = s[MISR_W-1] ? MISR_POLY : '0;
        return {s[MISR_W-2:0], 1'b0} ^ fb ^ MISR_W'(r);
    endfunction

    // A slot is free if the FIFO is not full or the consumer drains it this cycle.
    assign fifo_pop = !fifo_empty && bus.rec_ready;
    assign room     = !fifo_full || fifo_pop;
    assign last_vec = (vec_q == '1);
    // In STALL the response captured at the end of the hold window is reused.
    assign cur_resp = (state == ST_STALL) ? resp_hold : bus.dut_out;
    assign fifo_din = '{vec: vec_q, resp: cur_resp};

    tj_rec_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CK    (CK),
        .reset (reset),
        .push  (take),
        .din   (fifo_din),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    // FSM state register.
    always_ff @(posedge CK) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and per-cycle action strobes.
    always_comb begin
        state_nxt    = state;
        start_sweep  = 1'b0;
        hold_inc     = 1'b0;
        take         = 1'b0;
        capture_hold = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    start_sweep = 1'b1;
                    state_nxt   = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt == HOLD_LAST) state_nxt = ST_SAMPLE;
                else                       hold_inc  = 1'b1;
            end
            ST_SAMPLE: begin
                if (room) begin
                    take      = 1'b1;
                    state_nxt = last_vec ? ST_DONE : ST_DRIVE;
                end else begin
                    capture_hold = 1'b1;
                    state_nxt    = ST_STALL;
                end
            end
            ST_STALL: begin
                if (room) begin
                    take      = 1'b1;
                    state_nxt = last_vec ? ST_DONE : ST_DRIVE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Vector, hold counter, signature and status flags.
    always_ff @(posedge CK) begin
        if (reset) begin
            vec_q    <= '0;
            hold_cnt <= '0;
            sig_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (start_sweep) begin
                vec_q    <= '0;
                hold_cnt <= '0;
                sig_q    <= '0;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end
            if (hold_inc) hold_cnt <= hold_cnt + HC_W'(1);
            if (take) begin
                sig_q <= misr_next(sig_q, cur_resp);
                if (last_vec) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    vec_q    <= vec_q + IN_W'(1);
                    hold_cnt <= '0;
                end
            end
        end
    end

    // Response held across a FIFO-full stall.
    always_ff @(posedge CK) begin
        if (capture_hold) resp_hold <= bus.dut_out;
    end

    assign bus.dut_in    = vec_q;
    assign bus.signature = sig_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rec_valid = !fifo_empty;
    assign bus.rec_vec   = fifo_dout.vec;
    assign bus.rec_resp  = fifo_dout.resp;

endmodule

// File: tb/tb_tj_vector_sequencer.sv
// Directed bench for tj_vector_sequencer: three instances cover the default
// configuration, a 4-deep FIFO (stall path) and a 3-cycle hold window.
module tb_tj_vector_sequencer;

    logic       CK = 1'b0;
    logic       reset;
    int         checks = 0;
    int         errors = 0;
    logic [1:0] mode_a;
    logic [2:0] c_d1 = '0;
    logic [2:0] c_d2 = '0;

    always #5 CK = ~CK;

    tj_vector_sequencer_if #(.IN_W(3), .OUT_W(1), .MISR_W(16)) bus_a ();
    tj_vector_sequencer_if #(.IN_W(3), .OUT_W(1), .MISR_W(16)) bus_b ();
    tj_vector_sequencer_if #(.IN_W(3), .OUT_W(1), .MISR_W(16)) bus_c ();

    tj_vector_sequencer #(.IN_W(3), .OUT_W(1), .HOLD_CYCLES(1), .FIFO_DEPTH(8), .MISR_W(16))
        dut_a (.CK(CK), .reset(reset), .bus(bus_a));
    tj_vector_sequencer #(.IN_W(3), .OUT_W(1), .HOLD_CYCLES(1), .FIFO_DEPTH(4), .MISR_W(16))
        dut_b (.CK(CK), .reset(reset), .bus(bus_b));
    tj_vector_sequencer #(.IN_W(3), .OUT_W(1), .HOLD_CYCLES(3), .FIFO_DEPTH(8), .MISR_W(16))
        dut_c (.CK(CK), .reset(reset), .bus(bus_c));

    // DUT models: A selectable (0 parity, 1 constant 0, 2 high only at 111),
    // B parity, C parity of the vector applied two cycles earlier.
    assign bus_a.dut_out = (mode_a == 2'd0) ? ^bus_a.dut_in :
                           (mode_a == 2'd1) ? 1'b0 : &bus_a.dut_in;
    assign bus_b.dut_out = ^bus_b.dut_in;
    always @(posedge CK) begin
        c_d1 <= bus_c.dut_in;
        c_d2 <= c_d1;
    end
    assign bus_c.dut_out = ^c_d2;

    task automatic test_reset();
        mode_a = 2'd0;
        bus_a.rec_ready = 1'b0;
        @(negedge CK) bus_a.start = 1'b1;
        @(negedge CK) bus_a.start = 1'b0;
        repeat (7) @(negedge CK);
        checks++;
        if (bus_a.busy !== 1'b1 || bus_a.dut_in !== 3'd3 || bus_a.rec_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset got busy=%b dut_in=%0d rec_valid=%b want 1 3 1",
                     bus_a.busy, bus_a.dut_in, bus_a.rec_valid);
        end
        checks++;
        if (bus_a.signature !== 16'h0003) begin
            errors++;
            $display("FAIL pre_reset_sig got %h want 0003", bus_a.signature);
        end
        reset = 1'b1;
        repeat (2) @(negedge CK);
        reset = 1'b0;
        checks++;
        if (bus_a.dut_in !== 3'd0 || bus_a.busy !== 1'b0 || bus_a.done !== 1'b0 ||
            bus_a.rec_valid !== 1'b0 || bus_a.signature !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state got dut_in=%0d busy=%b done=%b rec_valid=%b sig=%h want 0 0 0 0 0000",
                     bus_a.dut_in, bus_a.busy, bus_a.done, bus_a.rec_valid, bus_a.signature);
        end
        @(negedge CK);
        checks++;
        if (bus_a.dut_in !== 3'd0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got dut_in=%0d busy=%b want 0 0", bus_a.dut_in, bus_a.busy);
        end
        bus_a.rec_ready = 1'b1;
    endtask

    task automatic test_sweep();
        int         n;
        int         first_done;
        logic [2:0] v;
        mode_a = 2'd0;
        n = 0;
        first_done = -1;
        @(negedge CK) bus_a.start = 1'b1;
        @(negedge CK) bus_a.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CK);
            if (bus_a.done === 1'b1 && first_done < 0) first_done = c;
            if (bus_a.rec_valid === 1'b1) begin
                v = n[2:0];
                checks++;
                if (n >= 8 || bus_a.rec_vec !== v || bus_a.rec_resp !== ^v) begin
                    errors++;
                    $display("FAIL sweep_rec%0d got vec=%b resp=%b want vec=%b resp=%b",
                             n, bus_a.rec_vec, bus_a.rec_resp, v, ^v);
                end
                n++;
            end
        end
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL sweep_count got %0d want 8", n);
        end
        checks++;
        if (first_done != 16) begin
            errors++;
            $display("FAIL sweep_done_latency got %0d want 16", first_done);
        end
        checks++;
        if (bus_a.signature !== 16'h0069 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL sweep_sig got sig=%h busy=%b want 0069 0", bus_a.signature, bus_a.busy);
        end
    endtask

    task automatic test_signature();
        int c;
        for (int pass = 0; pass < 2; pass++) begin
            mode_a = (pass == 0) ? 2'd1 : 2'd2;
            @(negedge CK) bus_a.start = 1'b1;
            @(negedge CK) bus_a.start = 1'b0;
            c = 0;
            while (bus_a.done !== 1'b1 && c < 40) begin
                @(negedge CK);
                c++;
            end
            checks++;
            if (bus_a.done !== 1'b1) begin
                errors++;
                $display("FAIL sig_done_timeout%0d got done=%b want 1", pass, bus_a.done);
            end
            checks++;
            if (bus_a.signature !== ((pass == 0) ? 16'h0000 : 16'h0001)) begin
                errors++;
                $display("FAIL sig_mode%0d got %h want %h", pass, bus_a.signature,
                         (pass == 0) ? 16'h0000 : 16'h0001);
            end
        end
        mode_a = 2'd0;
    endtask

    task automatic test_start_ignored();
        int first_done;
        int c;
        first_done = -1;
        @(negedge CK) bus_a.start = 1'b1;
        @(negedge CK) bus_a.start = 1'b0;
        repeat (6) @(negedge CK);
        checks++;
        if (bus_a.dut_in !== 3'd3) begin
            errors++;
            $display("FAIL ign_before got dut_in=%0d want 3", bus_a.dut_in);
        end
        bus_a.start = 1'b1;
        @(negedge CK) bus_a.start = 1'b0;
        checks++;
        if (bus_a.dut_in !== 3'd3 || bus_a.busy !== 1'b1) begin
            errors++;
            $display("FAIL ign_start got dut_in=%0d busy=%b want 3 1", bus_a.dut_in, bus_a.busy);
        end
        for (c = 8; c <= 40; c++) begin
            @(negedge CK);
            if (bus_a.done === 1'b1 && first_done < 0) first_done = c;
        end
        checks++;
        if (first_done != 16 || bus_a.signature !== 16'h0069) begin
            errors++;
            $display("FAIL ign_complete got done_at=%0d sig=%h want 16 0069", first_done, bus_a.signature);
        end
        @(negedge CK) bus_a.start = 1'b1;
        @(negedge CK) bus_a.start = 1'b0;
        checks++;
        if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b1 || bus_a.dut_in !== 3'd0 ||
            bus_a.signature !== 16'h0000) begin
            errors++;
            $display("FAIL restart got done=%b busy=%b dut_in=%0d sig=%h want 0 1 0 0000",
                     bus_a.done, bus_a.busy, bus_a.dut_in, bus_a.signature);
        end
        c = 0;
        while (bus_a.done !== 1'b1 && c < 40) begin
            @(negedge CK);
            c++;
        end
        checks++;
        if (bus_a.done !== 1'b1) begin
            errors++;
            $display("FAIL restart_timeout got done=%b want 1", bus_a.done);
        end
    endtask

    task automatic test_stall();
        int         n;
        logic [2:0] v;
        n = 0;
        @(negedge CK) bus_b.start = 1'b1;
        @(negedge CK) bus_b.start = 1'b0;
        repeat (12) @(negedge CK);
        checks++;
        if (bus_b.dut_in !== 3'd4 || bus_b.rec_vec !== 3'd0) begin
            errors++;
            $display("FAIL stall_early got dut_in=%0d rec_vec=%0d want 4 0", bus_b.dut_in, bus_b.rec_vec);
        end
        repeat (18) @(negedge CK);
        checks++;
        if (bus_b.dut_in !== 3'd4 || bus_b.busy !== 1'b1 || bus_b.done !== 1'b0 ||
            bus_b.rec_valid !== 1'b1 || bus_b.rec_vec !== 3'd0 || bus_b.rec_resp !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got dut_in=%0d busy=%b done=%b valid=%b vec=%0d resp=%b want 4 1 0 1 0 0",
                     bus_b.dut_in, bus_b.busy, bus_b.done, bus_b.rec_valid, bus_b.rec_vec, bus_b.rec_resp);
        end
        bus_b.rec_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus_b.rec_valid === 1'b1) begin
                v = n[2:0];
                checks++;
                if (n >= 8 || bus_b.rec_vec !== v || bus_b.rec_resp !== ^v) begin
                    errors++;
                    $display("FAIL stall_rec%0d got vec=%b resp=%b want vec=%b resp=%b",
                             n, bus_b.rec_vec, bus_b.rec_resp, v, ^v);
                end
                n++;
            end
            @(negedge CK);
        end
        checks++;
        if (n != 8 || bus_b.done !== 1'b1) begin
            errors++;
            $display("FAIL stall_count got n=%0d done=%b want 8 1", n, bus_b.done);
        end
    endtask

    task automatic test_hold();
        int         n;
        int         first_done;
        logic [2:0] v;
        n = 0;
        first_done = -1;
        @(negedge CK) bus_c.start = 1'b1;
        @(negedge CK) bus_c.start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge CK);
            if (bus_c.done === 1'b1 && first_done < 0) first_done = c;
            if (bus_c.rec_valid === 1'b1) begin
                v = n[2:0];
                checks++;
                if (n >= 8 || bus_c.rec_vec !== v || bus_c.rec_resp !== ^v) begin
                    errors++;
                    $display("FAIL hold_rec%0d got vec=%b resp=%b want vec=%b resp=%b",
                             n, bus_c.rec_vec, bus_c.rec_resp, v, ^v);
                end
                n++;
            end
        end
        checks++;
        if (n != 8 || first_done != 32) begin
            errors++;
            $display("FAIL hold_summary got n=%0d done_at=%0d want 8 32", n, first_done);
        end
    endtask

    initial begin
        reset = 1'b1;
        mode_a = 2'd0;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        bus_c.start = 1'b0;
        bus_a.rec_ready = 1'b1;
        bus_b.rec_ready = 1'b0;
        bus_c.rec_ready = 1'b1;
        repeat (3) @(negedge CK);
        reset = 1'b0;
        test_reset();
        test_sweep();
        test_signature();
        test_start_ignored();
        test_stall();
        test_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
